// File: rtl/maxnet_plu.sv
// Maxnet lateral-inhibition unit: one iteration per start_plu.
// Ports: clk, rst_n, start_plu, a_in[N*W], eps[W] -> a_out[N*W], plu_done, valid, busy.
module maxnet_plu #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start_plu,
  input  logic [N*W-1:0] a_in,
  input  logic [W-1:0]   eps,
  output logic [N*W-1:0] a_out,
  output logic           plu_done,
  output logic           valid,
  output logic           busy
);

  localparam int AW = W + $clog2(N);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = W + AW;

  typedef enum logic [1:0] {
    IDLE,
    SUM,
    UPD,
    DONE
  } state_t;

  state_t         state_q, state_d;
  logic [N*W-1:0] a_q, a_d;
  logic [W-1:0]   eps_q, eps_d;
  logic [AW-1:0]  acc_q, acc_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [N*W-1:0] buf_q, buf_d;
  logic [N*W-1:0] a_out_q, a_out_d;
  logic           valid_q, valid_d;

  logic [W-1:0]   a_cur;
  logic [AW-1:0]  others;
  logic [PW-1:0]  prod;
  logic [AW-1:0]  inhib;
  logic [W-1:0]   r_cur;
  logic           last;
  int unsigned    nz;

  // Inhibition term eps*(sum of the other neurons), full width,
  // then truncated by W; clamp to zero instead of wrapping.
  always_comb begin
    a_cur  = a_q[idx_q*W +: W];
    others = acc_q - AW'(a_cur);
    prod   = PW'(eps_q) * PW'(others);
    inhib  = AW'(prod >> W);
    r_cur  = (inhib >= AW'(a_cur)) ? '0 : a_cur - W'(inhib);
    last   = (idx_q == IW'(N - 1));
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    eps_d   = eps_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    a_out_d = a_out_q;
    valid_d = valid_q;
    nz      = 0;
    unique case (state_q)
      IDLE: begin
        if (start_plu) begin
          a_d     = a_in;
          eps_d   = eps;
          acc_d   = '0;
          idx_d   = '0;
          state_d = SUM;
        end
      end
      SUM: begin
        acc_d = acc_q + AW'(a_cur);
        if (last) begin
          idx_d   = '0;
          state_d = UPD;
        end else begin
          idx_d = IW'(idx_q + 1'b1);
        end
      end
      UPD: begin
        buf_d[idx_q*W +: W] = r_cur;
        if (last) begin
          idx_d = '0;
          for (int i = 0; i < N; i++) begin
            if (buf_d[i*W +: W] != '0) nz = nz + 1;
          end
          a_out_d = buf_d;
          valid_d = (nz <= 1);
          state_d = DONE;
        end else begin
          idx_d = IW'(idx_q + 1'b1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      eps_q   <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      buf_q   <= '0;
      a_out_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      eps_q   <= eps_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      a_out_q <= a_out_d;
      valid_q <= valid_d;
    end
  end

  assign a_out    = a_out_q;
  assign valid    = valid_q;
  assign plu_done = (state_q == DONE);
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_maxnet_plu.sv
// Scoreboard bench for maxnet_plu (N=4, W=8).
// Driver pushes expected results; monitor checks on plu_done.
module tb_maxnet_plu;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start_plu = 1'b0;
  logic [N*W-1:0] a_in = '0;
  logic [W-1:0]   eps = '0;
  logic [N*W-1:0] a_out;
  logic           plu_done;
  logic           valid;
  logic           busy;

  maxnet_plu #(.N(N), .W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_plu(start_plu),
    .a_in     (a_in),
    .eps      (eps),
    .a_out    (a_out),
    .plu_done (plu_done),
    .valid    (valid),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N*W-1:0] a;
    logic           v;
    int             c;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [N*W-1:0] pk(input int n0, input int n1,
                                        input int n2, input int n3);
    pk = {8'(n3), 8'(n2), 8'(n1), 8'(n0)};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  // Monitor: every plu_done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && plu_done) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: plu_done at cycle %0d, none expected",
                 cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("a_out", 64'(a_out), 64'(e.a));
        chk("valid", 64'(valid), 64'(e.v));
        chk("done_cycle", 64'(cyc), 64'(e.c));
      end
    end
  end

  task automatic run(input logic [N*W-1:0] a, input logic [W-1:0] e,
                     input logic [N*W-1:0] ea, input logic ev);
    @(negedge clk);
    a_in = a;
    eps = e;
    start_plu = 1'b1;
    sb.push_back('{ea, ev, cyc + 1 + 2*N});
    @(negedge clk);
    start_plu = 1'b0;
    repeat (2*N + 2) @(negedge clk);
  endtask

  logic [N*W-1:0] chain_in [4];
  logic [N*W-1:0] chain_ex [4];
  logic           chain_v  [4];

  initial begin
    int d;
    chain_ex[0] = pk(0, 0, 13, 25); chain_v[0] = 1'b0;
    chain_ex[1] = pk(0, 0, 7, 22);  chain_v[1] = 1'b0;
    chain_ex[2] = pk(0, 0, 2, 21);  chain_v[2] = 1'b0;
    chain_ex[3] = pk(0, 0, 0, 21);  chain_v[3] = 1'b1;
    for (int k = 0; k < 4; k++) chain_in[k] = chain_ex[k];

    #1;
    chk("rst_a_out", 64'(a_out), 64'(0));
    chk("rst_valid", 64'(valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(plu_done), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run(pk(10, 20, 30, 40), 8'h20, pk(0, 10, 22, 33), 1'b0);
    run(pk(0, 0, 1, 7), 8'h80, pk(0, 0, 0, 7), 1'b1);
    run(pk(0, 0, 5, 9), 8'h80, pk(0, 0, 1, 7), 1'b0);
    run(pk(3, 0, 255, 9), 8'h00, pk(3, 0, 255, 9), 1'b0);
    run(pk(0, 0, 0, 0), 8'h80, pk(0, 0, 0, 0), 1'b1);

    // Outputs hold while idle inputs wander.
    a_in = pk(1, 2, 3, 4);
    repeat (3) @(negedge clk);
    chk("hold_a_out", 64'(a_out), 64'(0));
    chk("hold_valid", 64'(valid), 64'(1));

    // Input changes and stray starts mid-run are ignored.
    @(negedge clk);
    a_in = pk(10, 20, 30, 40);
    eps = 8'h20;
    start_plu = 1'b1;
    sb.push_back('{pk(0, 10, 22, 33), 1'b0, cyc + 1 + 2*N});
    @(negedge clk);
    start_plu = 1'b0;
    @(negedge clk);
    a_in = pk(99, 1, 1, 1);
    eps = 8'hff;
    start_plu = 1'b1;
    @(negedge clk);
    start_plu = 1'b0;
    chk("busy_mid", 64'(busy), 64'(1));
    repeat (N) @(negedge clk);
    a_in = pk(5, 5, 5, 5);
    start_plu = 1'b1;
    @(negedge clk);
    start_plu = 1'b0;
    repeat (2*N) @(negedge clk);

    // Asynchronous reset in UPD aborts the run.
    @(negedge clk);
    a_in = pk(0, 0, 1, 7);
    eps = 8'h80;
    start_plu = 1'b1;
    @(negedge clk);
    start_plu = 1'b0;
    repeat (N + 1) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_a_out", 64'(a_out), 64'(0));
    chk("abort_valid", 64'(valid), 64'(0));
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_done", 64'(plu_done), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2*N + 2) @(negedge clk);
    run(pk(10, 20, 30, 40), 8'h20, pk(0, 10, 22, 33), 1'b0);

    // Back-to-back chain; start held high through DONE cycles.
    @(negedge clk);
    a_in = pk(10, 20, 30, 40);
    eps = 8'h40;
    start_plu = 1'b1;
    d = cyc + 1 + 2*N;
    for (int k = 0; k < 4; k++)
      sb.push_back('{chain_ex[k], chain_v[k], d + k*(2*N + 2)});
    for (int k = 0; k < 4; k++) begin
      while (cyc < d + k*(2*N + 2)) @(negedge clk);
      a_in = chain_in[k];
      if (k == 3) start_plu = 1'b0;
    end
    repeat (2*N + 4) @(negedge clk);

    chk("sb_empty", 64'(sb.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/maxnet_plu.md
MAXNET_PLU -- requirements
Module: maxnet_plu

Interface
REQ-001 SHALL have parameter N, default 4, number of neurons.
REQ-002 SHALL have parameter W, default 8, activation width (unsigned) and epsilon width (unsigned fraction, Q0.W).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start_plu  input  1  request to run one Maxnet iteration.
REQ-006 SHALL have port a_in  input  N*W  current activations; neuron i at bits [i*W +: W].
REQ-007 SHALL have port eps  input  W  inhibition weight; value = eps / 2^W.
REQ-008 SHALL have port a_out  output  N*W  iteration result, same packing as a_in.
REQ-009 SHALL have port plu_done  output  1  one-cycle pulse; iteration result available.
REQ-010 SHALL have port valid  output  1  high when at most one a_out element is nonzero.
REQ-011 SHALL have port busy  output  1  high while an iteration is in progress, including the DONE state.

Function
REQ-012 SHALL implement FSM states IDLE, SUM, UPD, DONE.
REQ-013 In IDLE with start_plu=1 at an edge, SHALL latch a_in and eps into internal registers, clear accumulator and index, and enter SUM.
REQ-014 SHALL ignore start_plu in SUM, UPD and DONE; no restart or re-latch.
REQ-015 SUM: one neuron per cycle, total += a[idx], for N cycles; after the Nth, reset idx to 0 and enter UPD.
REQ-016 Accumulator width SHALL be W+clog2(N); no overflow possible.
REQ-017 UPD: one neuron per cycle, r_i = a_i - ((eps * (total - a_i)) >> W), truncating shift; full-width product, no intermediate truncation.
REQ-018 If the shifted product >= a_i, r_i SHALL be 0 (clamp at zero, no wrap).
REQ-019 r_i SHALL go to a working buffer; a_out SHALL hold its previous value until DONE.
REQ-020 After N UPD cycles, SHALL load a_out from the working buffer, load valid = (count of nonzero r_i <= 1), and enter DONE.
REQ-021 DONE SHALL last exactly one cycle with plu_done=1, then return to IDLE.
REQ-022 Latency: start sampled at edge 0 -> plu_done high between edges 2N and 2N+1 (edges 8 and 9 for N=4); busy high from edge 0 to edge 2N+1.
REQ-023 a_out and valid SHALL hold until the next DONE load; changes on a_in/eps after latching SHALL not affect the running iteration.
REQ-024 start_plu high in the DONE cycle SHALL be ignored; start_plu high in the first IDLE cycle after DONE SHALL start a new iteration (back-to-back supported).
REQ-025 eps=0 SHALL give a_out == latched a_in; all-zero input SHALL give all-zero output with valid=1.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, a_out=0, valid=0, plu_done=0, busy=0, and clear accumulator, index and buffer, independent of clk.
REQ-027 Reset mid-iteration SHALL abort it; no plu_done for the aborted run; the first start after rst_n rises SHALL behave per REQ-022.

Verification
REQ-028 N=4,W=8: a_in={10,20,30,40} (neuron0..3), eps=0x20 -> a_out={0,10,22,33}, valid=0, plu_done after edge 8.
REQ-029 a_in={0,0,1,7}, eps=0x80 -> a_out={0,0,0,7}, valid=1; a_in={0,0,5,9}, eps=0x80 -> a_out={0,0,1,7}, valid=0.
REQ-030 eps=0x00, a_in={3,0,255,9} -> a_out={3,0,255,9}; a_in all zero -> a_out zero, valid=1.
REQ-031 Change a_in and pulse start_plu during SUM/UPD -> result matches the originally latched a_in; exactly one plu_done.
REQ-032 Assert rst_n=0 in UPD mid-run -> outputs zero at once, no plu_done; a new start gives correct result at the REQ-022 latency.
REQ-033 Chain back-to-back iterations feeding a_out to a_in from {10,20,30,40}, eps=0x40 -> valid rises within a bounded number of runs, and only neuron3 stays nonzero.
